// File: rtl/vga_line_fetch.sv
// vga_line_fetch
//   Line-prefetch sequencer for the VGA ping-pong line buffer (sys_clk domain).
//   On each line_start it reads the NEXT scanline (LINE_WORDS words) from the
//   framebuffer over a req/ack master port. Each word goes into the idle bank
//   of the line buffer. The pixel-domain timing generator reads the other bank.
//
// Ports
//   sys_clk, rst          clock (rising edge); asynchronous active-low reset
//   enable                1 = fetching allowed
//   frame_start           1-cycle pulse; latches fb_base and clears underrun
//   line_start, line_num  1-cycle pulse plus the line now being displayed
//   fb_base               framebuffer base word address
//   mem_req/addr/ack/rdata  memory read master (ack is 1 cycle, data same cycle)
//   buf_ce/we/addr/wdat   line-buffer write port, buf_addr = {bank, idx[9:0]}
//   busy                  state != IDLE
//   line_done             1-cycle pulse after the last word of a line is written
//   underrun              sticky flag: a line_start arrived while busy
module vga_line_fetch #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 17,
    parameter int LINE_WORDS = 320,
    parameter int V_LINES    = 240
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic [9:0]        line_num,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              buf_ce,
    output logic              buf_we,
    output logic [10:0]       buf_addr,
    output logic [DATA_W-1:0] buf_wdat,
    output logic              busy,
    output logic              line_done,
    output logic              underrun
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE} state_e;

    localparam logic [ADDR_W-1:0] LW_A    = ADDR_W'(LINE_WORDS);
    localparam logic [9:0]        LAST    = 10'(LINE_WORDS - 1);
    localparam logic [9:0]        LAST_LN = 10'(V_LINES - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   row_q;
    logic [9:0]          idx_q;
    logic                bank_q;

    logic                mem_req_q, buf_ce_q, buf_we_q, busy_q, line_done_q, underrun_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [10:0]         buf_addr_q;
    logic [DATA_W-1:0]   buf_wdat_q;

    logic [9:0]          tgt_d;
    logic [ADDR_W-1:0]   base_d;
    logic [ADDR_W-1:0]   row_d;

    // Next line to fetch. Out-of-range line numbers are treated as a wrap.
    assign tgt_d  = (line_num >= LAST_LN) ? 10'd0 : line_num + 10'd1;
    // A frame_start coinciding with line_start must already use the new base.
    assign base_d = frame_start ? fb_base : base_q;
    // The row base is computed once per line, so the per-word path is one add.
    assign row_d  = base_d + ADDR_W'(tgt_d) * LW_A;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            row_q       <= '0;
            idx_q       <= '0;
            bank_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            buf_ce_q    <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdat_q  <= '0;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            line_done_q <= 1'b0;

            if (frame_start) begin
                base_q     <= fb_base;
                underrun_q <= 1'b0;
            end
            // A line_start while busy does not restart anything. It only flags
            // that the previous line was late. If frame_start arrives in the
            // same cycle, the set wins over the clear.
            if (line_start && state_q != IDLE)
                underrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (line_start && enable) begin
                        bank_q     <= tgt_d[0];
                        row_q      <= row_d;
                        idx_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= row_d;
                        busy_q     <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    // The request is held until ack, even if enable drops.
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        buf_ce_q   <= 1'b1;
                        buf_we_q   <= 1'b1;
                        buf_addr_q <= {bank_q, idx_q};
                        buf_wdat_q <= mem_rdata;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    buf_ce_q <= 1'b0;
                    buf_we_q <= 1'b0;
                    if (idx_q == LAST) begin
                        line_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end else if (!enable) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        idx_q      <= idx_q + 10'd1;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= row_q + ADDR_W'(idx_q + 10'd1);
                        state_q    <= REQ;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign buf_ce    = buf_ce_q;
    assign buf_we    = buf_we_q;
    assign buf_addr  = buf_addr_q;
    assign buf_wdat  = buf_wdat_q;
    assign busy      = busy_q;
    assign line_done = line_done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Directed bench for vga_line_fetch. A behavioural memory acknowledges each
// request after a programmable latency and returns data derived from the address.
// A write monitor checks every buffer write against the expected row base and bank.
module tb_vga_line_fetch;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  line_num = '0;
    logic [16:0] fb_base = '0;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        buf_ce, buf_we;
    logic [10:0] buf_addr;
    logic [7:0]  buf_wdat;
    logic        busy, line_done, underrun;

    vga_line_fetch dut (
        .sys_clk(sys_clk), .rst(rst), .enable(enable),
        .frame_start(frame_start), .line_start(line_start), .line_num(line_num),
        .fb_base(fb_base), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .buf_ce(buf_ce), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_wdat(buf_wdat), .busy(busy),
        .line_done(line_done), .underrun(underrun)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [7:0] fdat(input logic [16:0] a);
        return a[7:0] ^ a[15:8] ^ {7'd0, a[16]};
    endfunction

    // Memory responder: after the request has been seen for lat cycles, ack it.
    int lat = 0;
    int lcnt = 0;
    initial forever begin
        @(posedge sys_clk); #1;
        if (mem_req && !mem_ack) begin
            if (lcnt >= lat) begin
                mem_ack   = 1'b1;
                mem_rdata = fdat(mem_addr);
                lcnt      = 0;
            end else lcnt++;
        end else begin
            mem_ack = 1'b0;
            lcnt    = 0;
        end
    end

    // Write / handshake monitor, sampled on the falling edge.
    logic [16:0] exp_row = '0;
    logic        exp_bank = 1'b0;
    int          wr_total = 0, ld_total = 0, bad = 0, line_idx = 0;
    logic [10:0] first_waddr = '0, last_waddr = '0;
    logic [16:0] last_ack_addr = '0;
    always @(negedge sys_clk) begin
        if (mem_req && mem_ack) last_ack_addr = mem_addr;
        if (line_done) ld_total++;
        if (buf_ce !== buf_we) bad++;
        if (buf_we) begin
            if (buf_addr[9:0] == 10'd0) begin
                line_idx    = 0;
                first_waddr = buf_addr;
            end
            if (buf_addr[9:0] != 10'(line_idx)) bad++;
            if (buf_addr[10] !== exp_bank) bad++;
            if (buf_wdat !== fdat(exp_row + 17'(buf_addr[9:0]))) bad++;
            last_waddr = buf_addr;
            line_idx++;
            wr_total++;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic pulse_frame(input logic [16:0] b);
        frame_start = 1'b1; fb_base = b;
        tick();
        frame_start = 1'b0;
    endtask

    // Pulses line_start; returns mem_req/mem_addr seen right after the sampling edge.
    task automatic pulse_line(input logic [9:0] n, input logic with_frame,
                              input logic [16:0] b, output logic req0, output logic [16:0] a0);
        line_start = 1'b1; line_num = n;
        if (with_frame) begin frame_start = 1'b1; fb_base = b; end
        tick();
        req0 = mem_req; a0 = mem_addr;
        line_start = 1'b0; frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output int cyc);
        cyc = 0;
        while (busy && cyc < maxc) begin tick(); cyc++; end
    endtask

    int          w0, l0, cyc;
    logic        r0;
    logic [16:0] a0;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_buf_we", 32'(buf_we), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_buf_addr", 32'(buf_addr), 0);
        rst = 1'b1; enable = 1'b1;
        tick();

        // Basic line: base 0x1000, line 4 -> target 5, bank 1
        pulse_frame(17'h01000);
        exp_row = 17'h01640; exp_bank = 1'b1;
        w0 = wr_total; l0 = ld_total;
        pulse_line(10'd4, 1'b0, '0, r0, a0);
        chk("basic_req0", 32'(r0), 1);
        chk("basic_addr0", 32'(a0), 32'h1640);
        wait_idle(2000, cyc);
        chk("basic_timeout", 32'(busy), 0);
        chk("basic_min_cycles", 32'(cyc >= 630), 1);
        tick();
        chk("basic_writes", 32'(wr_total - w0), 320);
        chk("basic_done", 32'(ld_total - l0), 1);
        chk("basic_first_waddr", 32'(first_waddr), 32'h400);
        chk("basic_last_waddr", 32'(last_waddr), 32'h53F);
        chk("basic_last_maddr", 32'(last_ack_addr), 32'h177F);
        chk("basic_bad", 32'(bad), 0);

        // Wrap: line 239 -> target 0, bank 0
        exp_row = 17'h01000; exp_bank = 1'b0;
        w0 = wr_total; l0 = ld_total;
        pulse_line(10'd239, 1'b0, '0, r0, a0);
        chk("wrap_addr0", 32'(a0), 32'h1000);
        wait_idle(2000, cyc);
        tick();
        chk("wrap_writes", 32'(wr_total - w0), 320);
        chk("wrap_done", 32'(ld_total - l0), 1);
        chk("wrap_first_waddr", 32'(first_waddr), 32'h000);
        chk("wrap_last_waddr", 32'(last_waddr), 32'h13F);
        chk("wrap_last_maddr", 32'(last_ack_addr), 32'h113F);

        // Out-of-range line number also wraps to target 0
        pulse_line(10'd300, 1'b0, '0, r0, a0);
        chk("oor_addr0", 32'(a0), 32'h1000);
        wait_idle(2000, cyc);
        tick();
        chk("oor_bad", 32'(bad), 0);

        // Underrun: base 0x2000, line 10 -> target 11, row 0x2000+11*320=0x2DC0
        pulse_frame(17'h02000);
        exp_row = 17'h02DC0; exp_bank = 1'b1;
        w0 = wr_total; l0 = ld_total;
        pulse_line(10'd10, 1'b0, '0, r0, a0);
        chk("ur_addr0", 32'(a0), 32'h2DC0);
        chk("ur_flag_before", 32'(underrun), 0);
        repeat (100) tick();
        pulse_line(10'd50, 1'b0, '0, r0, a0);
        chk("ur_flag_set", 32'(underrun), 1);
        chk("ur_still_busy", 32'(busy), 1);
        wait_idle(2000, cyc);
        tick();
        chk("ur_writes", 32'(wr_total - w0), 320);
        chk("ur_done", 32'(ld_total - l0), 1);
        chk("ur_last_maddr", 32'(last_ack_addr), 32'h2EFF);
        chk("ur_bad", 32'(bad), 0);
        chk("ur_sticky", 32'(underrun), 1);
        pulse_frame(17'h01000);
        chk("ur_cleared", 32'(underrun), 0);

        // Disable while a request waits for a slow ack
        lat = 5;
        exp_row = 17'h01640; exp_bank = 1'b1;
        w0 = wr_total; l0 = ld_total;
        pulse_line(10'd4, 1'b0, '0, r0, a0);
        enable = 1'b0;
        tick();
        chk("dis_req_held1", 32'(mem_req), 1);
        tick();
        chk("dis_req_held2", 32'(mem_req), 1);
        chk("dis_addr_held", 32'(mem_addr), 32'h1640);
        wait_idle(100, cyc);
        chk("dis_idle", 32'(busy), 0);
        tick();
        chk("dis_writes", 32'(wr_total - w0), 1);
        chk("dis_no_done", 32'(ld_total - l0), 0);
        chk("dis_req_low", 32'(mem_req), 0);
        pulse_line(10'd4, 1'b0, '0, r0, a0);
        chk("dis_ignored", 32'(busy), 0);
        enable = 1'b1; lat = 0;
        tick();

        // Address overflow: base 0x1FFFF with frame_start coinciding, target 1
        exp_row = 17'h0013F; exp_bank = 1'b1;
        w0 = wr_total;
        pulse_line(10'd0, 1'b1, 17'h1FFFF, r0, a0);
        chk("ovf_addr0", 32'(a0), 32'h0013F);
        wait_idle(2000, cyc);
        tick();
        chk("ovf_writes", 32'(wr_total - w0), 320);
        chk("ovf_last_maddr", 32'(last_ack_addr), 32'h0027E);
        chk("ovf_bad", 32'(bad), 0);

        // Reset mid-REQ, with underrun set
        lat = 50;
        pulse_line(10'd4, 1'b0, '0, r0, a0);
        repeat (3) tick();
        pulse_line(10'd5, 1'b0, '0, r0, a0);
        chk("mid_req_up", 32'(mem_req), 1);
        chk("mid_ur_up", 32'(underrun), 1);
        rst = 1'b0;
        tick();
        chk("mid_rst_req", 32'(mem_req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_we", 32'(buf_we), 0);
        chk("mid_rst_ur", 32'(underrun), 0);
        rst = 1'b1;
        lat = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
